// File: rtl/fifo_stream_pkg.sv
// Shared defaults and types for the FIFO-to-stream adapter.
package fifo_stream_pkg;

  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned BURST_LEN       = 4;
  localparam int unsigned FRAME_CNT_WIDTH = 16;

  // Output buffer depth and the width of a counter holding 0..BUF_DEPTH.
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // Beat counter width: clog2(burst_len), at least one bit.
  function automatic int unsigned beat_cnt_width(input int unsigned burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry ring buffer that absorbs the FIFO read latency.
module stream_buf2
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DW = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [DW-1:0]    head_data_o
);

  logic [DW-1:0]    mem_q [BUF_DEPTH];
  logic             head_q;
  logic             tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and 1-bit pointers; pointers wrap naturally modulo 2.
  always_ff @(posedge clk) begin
    if (rstn) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= ~tail_q;
      end
      if (pop_i) head_q <= ~head_q;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/fifo_stream_adapter.sv
// Reads sync_fifo and presents its words as a valid/ready stream with framing.
module fifo_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int unsigned data_width      = DATA_WIDTH,
  parameter int unsigned burst_len       = BURST_LEN,
  parameter int unsigned frame_cnt_width = FRAME_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  output logic                       rd_ena,
  input  logic [data_width-1:0]      data_out,
  input  logic                       empty,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [data_width-1:0]      m_data,
  output logic                       m_last,
  output logic [frame_cnt_width-1:0] frame_cnt
);

  localparam int unsigned             BEAT_W    = beat_cnt_width(burst_len);
  localparam logic [BEAT_W-1:0]       BEAT_LAST = BEAT_W'(burst_len - 1);
  localparam int unsigned             CU_W      = CNT_W + 1;

  logic                       inflight_q;
  logic [BEAT_W-1:0]          beat_cnt_q;
  logic [BEAT_W-1:0]          beat_cnt_d;
  logic [frame_cnt_width-1:0] frame_cnt_q;
  logic [frame_cnt_width-1:0] frame_cnt_d;
  logic [CNT_W-1:0]           count;
  logic [data_width-1:0]      head_data;
  logic                       pop;
  logic                       at_last;
  logic [CU_W-1:0]            credit_use;

  stream_buf2 #(
    .DW (data_width)
  ) u_buf (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (inflight_q),
    .push_data_i (data_out),
    .pop_i       (pop),
    .count_o     (count),
    .head_data_o (head_data)
  );

  assign m_valid = (count != '0);
  assign m_data  = head_data;
  assign pop     = m_valid & m_ready;
  assign at_last = (beat_cnt_q == BEAT_LAST);
  assign m_last  = m_valid & at_last;

  // Credit: slots already used or promised, after this cycle's pop frees one.
  assign credit_use = CU_W'(count) + CU_W'(inflight_q) - CU_W'(pop);
  assign rd_ena     = ~empty & ~rstn & (credit_use < CU_W'(BUF_DEPTH));

  // Beat position within the frame and completed-frame count.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      if (at_last) begin
        beat_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + frame_cnt_width'(1);
      end else begin
        beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
      end
    end
  end

  // Read-in-flight flag and framing counters.
  always_ff @(posedge clk) begin
    if (rstn) begin
      inflight_q  <= 1'b0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      inflight_q  <= rd_ena;
      beat_cnt_q  <= beat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;

  // Buffered plus in-flight words must never exceed the buffer depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (rstn)
    (CU_W'(count) + CU_W'(inflight_q)) <= CU_W'(BUF_DEPTH));

endmodule
